// File: rtl/load_store_unit.sv
//------------------------------------------------------------------------------
// Module      : load_store_unit
// Description : Sequences RV32I loads/stores onto a single-request data bus,
//               forms byte enables / replicated store data, extends load data.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Start,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic        BusReq,
    output logic        BusWe,
    output logic [31:0] BusAddr,
    output logic [3:0]  BusBE,
    output logic [31:0] BusWData,
    input  logic        BusGnt,
    input  logic        BusRValid,
    input  logic [31:0] BusRData,
    output logic [31:0] ReadData,
    output logic        Busy,
    output logic        Done,
    output logic        Err,
    output logic [1:0]  ErrCause
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_FIN  = 3'd3,
        S_FAIL = 3'd4
    } state_t;

    localparam logic [15:0] c_CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [15:0] r_cnt;
    logic [1:0]  r_cause;
    logic [31:0] r_rdata;

    logic        w_capture;
    logic [1:0]  w_cause;
    logic        w_illegal;
    logic        w_misaligned;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;
    logic        w_in_req;

    // Decode uses the live inputs: it only matters in the IDLE cycle that sees Start.
    assign w_illegal    = (Funct3 == 3'b011) || (Funct3[2] && Funct3[1]) ||
                          (MemWrite && Funct3[2]);
    assign w_misaligned = ((Funct3[1:0] == 2'b01) && Addr[0]) ||
                          ((Funct3[1:0] == 2'b10) && (Addr[1:0] != 2'b00));

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_cause   = r_cause;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    if (w_illegal) begin
                        w_next  = S_FAIL;
                        w_cause = 2'b10;
                    end else if (w_misaligned) begin
                        w_next  = S_FAIL;
                        w_cause = 2'b01;
                    end else begin
                        w_next = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (BusGnt && (r_we || BusRValid)) begin
                    w_next    = S_FIN;
                    w_capture = !r_we;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_next  = S_FAIL;
                    w_cause = 2'b11;
                end else if (BusGnt) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (BusRValid) begin
                    w_next    = S_FIN;
                    w_capture = 1'b1;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_next  = S_FAIL;
                    w_cause = 2'b11;
                end
            end
            S_FIN:   w_next = S_IDLE;
            S_FAIL:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_f3    <= 3'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_cnt   <= 16'd0;
            r_cause <= 2'b00;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_next;
            r_cause <= w_cause;
            if (r_state == S_IDLE && Start) begin
                r_we    <= MemWrite;
                r_f3    <= Funct3;
                r_addr  <= Addr;
                r_wdata <= WriteData;
            end
            if (r_state == S_REQ || r_state == S_WAIT) begin
                r_cnt <= r_cnt + 16'd1;
            end else begin
                r_cnt <= 16'd0;
            end
            if (w_capture) begin
                r_rdata <= w_ext;
            end
        end
    end

    assign w_byte = BusRData[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = BusRData[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        case (r_f3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = BusRData;
        endcase
    end

    // Bus-side outputs are forced to zero outside REQ so reset leaves them clear.
    assign w_in_req = (r_state == S_REQ);
    assign BusReq   = w_in_req;
    assign BusWe    = w_in_req && r_we;
    assign BusAddr  = w_in_req ? {r_addr[31:2], 2'b00} : 32'd0;

    always_comb begin
        BusBE    = 4'b0000;
        BusWData = 32'd0;
        if (w_in_req) begin
            if (r_we) begin
                case (r_f3[1:0])
                    2'b00: begin
                        BusBE    = 4'b0001 << r_addr[1:0];
                        BusWData = {4{r_wdata[7:0]}};
                    end
                    2'b01: begin
                        BusBE    = 4'b0011 << {r_addr[1], 1'b0};
                        BusWData = {2{r_wdata[15:0]}};
                    end
                    default: begin
                        BusBE    = 4'b1111;
                        BusWData = r_wdata;
                    end
                endcase
            end else begin
                BusBE = 4'b1111;
            end
        end
    end

    assign ReadData = r_rdata;
    assign Busy     = (r_state != S_IDLE);
    assign Done     = (r_state == S_FIN);
    assign Err      = (r_state == S_FAIL);
    assign ErrCause = (r_state == S_FAIL) ? r_cause : 2'b00;

endmodule

`default_nettype wire
